// File: rtl/pc_gen_bp_pkg.sv
// Shared definitions for the next-PC unit: NPCOp encodings, counter states and
// the BTB index-width helper.
package pc_gen_bp_pkg;

  typedef enum logic [4:0] {
    NPC_PLUS4  = 5'b00000,
    NPC_BRANCH = 5'b00001,
    NPC_JUMP   = 5'b00010,
    NPC_JALR   = 5'b00100
  } npc_op_e;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  function automatic int unsigned btb_idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/btb_2bc.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// One combinational lookup port and one edge-triggered training port.
module btb_2bc
  import pc_gen_bp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] lk_pc_i,
  output logic            lk_taken_o,
  output logic [XLEN-1:0] lk_target_o,
  input  logic            tr_en_i,
  input  logic            tr_jump_i,
  input  logic            tr_taken_i,
  input  logic [XLEN-1:0] tr_pc_i,
  input  logic [XLEN-1:0] tr_target_i
);

  localparam int unsigned IW = btb_idx_w(ENTRIES);
  localparam int unsigned TW = XLEN - IW - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TW-1:0]      tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IW-1:0] lk_idx, tr_idx;
  logic [TW-1:0] lk_tag, tr_tag;
  logic          lk_hit, tr_hit;
  logic [1:0]    tr_ctr_d;
  logic          unused_pc_lsbs;

  assign lk_idx = lk_pc_i[IW+1:2];
  assign lk_tag = lk_pc_i[XLEN-1:IW+2];
  assign tr_idx = tr_pc_i[IW+1:2];
  assign tr_tag = tr_pc_i[XLEN-1:IW+2];
  assign unused_pc_lsbs = ^{lk_pc_i[1:0], tr_pc_i[1:0]};

  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken_o  = lk_hit && ctr_q[lk_idx][1];
  assign lk_target_o = tgt_q[lk_idx];

  assign tr_hit = valid_q[tr_idx] && (tag_q[tr_idx] == tr_tag);

  always_comb begin
    tr_ctr_d = ctr_q[tr_idx];
    if (tr_jump_i) begin
      tr_ctr_d = CTR_ST;
    end else if (!tr_hit) begin
      tr_ctr_d = tr_taken_i ? CTR_WT : CTR_WNT;
    end else if (tr_taken_i) begin
      if (ctr_q[tr_idx] != CTR_ST) tr_ctr_d = ctr_q[tr_idx] + 2'd1;
    end else begin
      if (ctr_q[tr_idx] != CTR_SNT) tr_ctr_d = ctr_q[tr_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= CTR_WNT;
      end
    end else if (tr_en_i) begin
      valid_q[tr_idx] <= 1'b1;
      tag_q[tr_idx]   <= tr_tag;
      tgt_q[tr_idx]   <= tr_target_i;
      ctr_q[tr_idx]   <= tr_ctr_d;
    end
  end

endmodule

// File: rtl/pc_gen_bp.sv
// IF-stage PC register with BTB-based next-PC prediction and EX-stage
// resolution / misprediction redirect.
module pc_gen_bp
  import pc_gen_bp_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter bit              BP_EN       = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            ex_valid_i,
  input  logic [4:0]      ex_npcop_i,
  input  logic            ex_taken_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic [XLEN-1:0] ex_aluout_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  output logic            redirect_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4, btb_target;
  logic            btb_taken;
  logic [XLEN-1:0] ex_seq, ex_br_target, act_target, act_next;
  logic            act_taken;
  logic            tr_en, tr_jump;
  logic            unused_ex;

  assign unused_ex = ^{ex_pred_taken_i, ex_aluout_i[0]};

  btb_2bc #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rstn        (rstn),
    .lk_pc_i     (pc_q),
    .lk_taken_o  (btb_taken),
    .lk_target_o (btb_target),
    .tr_en_i     (tr_en),
    .tr_jump_i   (tr_jump),
    .tr_taken_i  (ex_taken_i),
    .tr_pc_i     (ex_pc_i),
    .tr_target_i (ex_br_target)
  );

  assign pc_o          = pc_q;
  assign pc_plus4      = pc_q + XLEN'(4);
  assign pred_taken_o  = BP_EN && btb_taken;
  assign pred_target_o = pred_taken_o ? btb_target : pc_plus4;

  assign ex_seq       = ex_pc_i + XLEN'(4);
  assign ex_br_target = ex_pc_i + ex_imm_i;

  // Unrecognised NPCOp values fall through to the sequential default.
  always_comb begin
    act_taken  = 1'b0;
    act_target = ex_seq;
    tr_en      = 1'b0;
    tr_jump    = 1'b0;
    case (ex_npcop_i)
      NPC_BRANCH: begin
        act_taken  = ex_taken_i;
        act_target = ex_br_target;
        tr_en      = ex_valid_i;
      end
      NPC_JUMP: begin
        act_taken  = 1'b1;
        act_target = ex_br_target;
        tr_en      = ex_valid_i;
        tr_jump    = 1'b1;
      end
      NPC_JALR: begin
        act_taken  = 1'b1;
        act_target = {ex_aluout_i[XLEN-1:1], 1'b0};
      end
      default: ;
    endcase
  end

  assign act_next   = act_taken ? act_target : ex_seq;
  assign redirect_o = ex_valid_i && (ex_pred_target_i != act_next);

  always_comb begin
    pc_d = pred_target_o;
    if (redirect_o)   pc_d = act_next;
    else if (stall_i) pc_d = pc_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

endmodule
